// File: rtl/sram_fifo_rd_streamer.sv
// sram_fifo_rd_streamer
//   Read-side engine for an sram_fifo. Issues FIFO reads under a credit limit,
//   captures returned words in a small prefetch ring, and unpacks each word
//   LSB-first into OUT_W symbols on a valid/ready stream. It also flags the
//   last symbol of every FRAME_SYMS-symbol frame.
// Ports
//   i_clk, i_rst_n          clock, async active-low reset
//   i_enable                allow new FIFO reads
//   i_fifo_empty            FIFO empty status
//   o_fifo_rd_req           FIFO read request (one word per asserted cycle)
//   i_fifo_rd_data_val/_data returned word strobe / word
//   o_out_valid/i_out_ready/o_out_data/o_out_last   symbol stream
//   o_busy                  words outstanding or buffered
//   o_err_unexp_val         sticky: return strobe seen with nothing outstanding
module sram_fifo_rd_streamer #(
  parameter int DATA_W     = 32,
  parameter int OUT_W      = 8,
  parameter int BUF_DEPTH  = 2,
  parameter int FRAME_SYMS = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_fifo_empty,
  output logic              o_fifo_rd_req,
  input  logic              i_fifo_rd_data_val,
  input  logic [DATA_W-1:0] i_fifo_rd_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [OUT_W-1:0]  o_out_data,
  output logic              o_out_last,
  output logic              o_busy,
  output logic              o_err_unexp_val
);

  localparam int SYMS      = DATA_W / OUT_W;
  localparam int SYM_IDX_W = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam int FRM_W     = (FRAME_SYMS > 1) ? $clog2(FRAME_SYMS) : 1;
  localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

  logic [DATA_W-1:0]    r_buf [BUF_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]     r_buf_cnt, r_outst;
  logic [SYM_IDX_W-1:0] r_sym_idx;
  logic [FRM_W-1:0]     r_frame_cnt;
  logic                 r_err;

  logic [CNT_W:0]       w_credit;
  logic                 w_accept, w_unexp, w_hs, w_pop, w_frm_end;
  logic [DATA_W-1:0]    w_head;
  logic [OUT_W-1:0]     w_syms [SYMS];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Words buffered plus words in flight never exceed BUF_DEPTH, so every
  // returned word is guaranteed a free slot without backpressure to the FIFO.
  assign w_credit      = (CNT_W+1)'(r_buf_cnt) + (CNT_W+1)'(r_outst);
  assign o_fifo_rd_req = i_enable & ~i_fifo_empty & (w_credit < (CNT_W+1)'(BUF_DEPTH));

  // A return with nothing outstanding is dropped; only the sticky flag records it.
  assign w_accept = i_fifo_rd_data_val & (r_outst != '0);
  assign w_unexp  = i_fifo_rd_data_val & (r_outst == '0);

  assign o_out_valid = (r_buf_cnt != '0);
  assign w_hs        = o_out_valid & i_out_ready;
  assign w_pop       = w_hs & (r_sym_idx == SYM_IDX_W'(SYMS - 1));
  assign w_frm_end   = (r_frame_cnt == FRM_W'(FRAME_SYMS - 1));

  assign w_head = r_buf[r_rd_ptr];
  for (genvar g = 0; g < SYMS; g++) begin : g_unpack
    assign w_syms[g] = w_head[g*OUT_W +: OUT_W];
  end

  assign o_out_data      = o_out_valid ? w_syms[r_sym_idx] : '0;
  assign o_out_last      = o_out_valid & w_frm_end;
  assign o_busy          = (r_outst != '0) | (r_buf_cnt != '0);
  assign o_err_unexp_val = r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_buf_cnt   <= '0;
      r_outst     <= '0;
      r_sym_idx   <= '0;
      r_frame_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_outst   <= r_outst + CNT_W'(o_fifo_rd_req) - CNT_W'(w_accept);
      r_buf_cnt <= r_buf_cnt + CNT_W'(w_accept) - CNT_W'(w_pop);
      if (w_accept) begin
        r_buf[r_wr_ptr] <= i_fifo_rd_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_hs) begin
        r_sym_idx   <= w_pop ? '0 : r_sym_idx + 1'b1;
        r_frame_cnt <= w_frm_end ? '0 : r_frame_cnt + 1'b1;
      end
      if (w_unexp) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_fifo_rd_streamer.sv
// Bench for sram_fifo_rd_streamer: a 1-cycle-latency FIFO model feeds the DUT.
// The reference is a queue of expected symbols plus an in-flight word count.
module tb_sram_fifo_rd_streamer;
  localparam int DATA_W = 32, OUT_W = 8, BUF_DEPTH = 2, FRAME_SYMS = 16;
  localparam int SYMS = DATA_W / OUT_W;

  logic              i_clk = 0, i_rst_n = 1, i_enable = 0, i_fifo_empty = 1;
  logic              o_fifo_rd_req, i_fifo_rd_data_val = 0;
  logic [DATA_W-1:0] i_fifo_rd_data = '0;
  logic              o_out_valid, i_out_ready = 0, o_out_last, o_busy, o_err_unexp_val;
  logic [OUT_W-1:0]  o_out_data;

  sram_fifo_rd_streamer #(.DATA_W(DATA_W), .OUT_W(OUT_W), .BUF_DEPTH(BUF_DEPTH),
                          .FRAME_SYMS(FRAME_SYMS)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_fifo_empty(i_fifo_empty),
    .o_fifo_rd_req(o_fifo_rd_req), .i_fifo_rd_data_val(i_fifo_rd_data_val),
    .i_fifo_rd_data(i_fifo_rd_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_data(o_out_data), .o_out_last(o_out_last), .o_busy(o_busy),
    .o_err_unexp_val(o_err_unexp_val));

  always #5 i_clk = ~i_clk;

  int tests = 0, errs = 0;
  logic [DATA_W-1:0] fifo_q [$];   // words still in the FIFO
  logic [OUT_W-1:0]  exp_q  [$];   // symbols of words requested but not yet consumed
  int   outst = 0;                 // words requested but not yet returned
  int   hs = 0;                    // handshakes since reset
  logic err_m = 0, ret_val = 0, inject = 0, en = 0, saw_req = 0;
  logic [DATA_W-1:0] ret_data = '0;
  int   rdy_pct = 100;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    int held;
    logic mv;
    logic [DATA_W-1:0] w, t;
    @(posedge i_clk); #1;
    if (inject) begin
      i_fifo_rd_data_val = 1; i_fifo_rd_data = 32'hDEADBEEF; inject = 0;
    end else begin
      i_fifo_rd_data_val = ret_val; i_fifo_rd_data = ret_data;
    end
    i_fifo_empty = (fifo_q.size() == 0);
    i_enable     = en;
    i_out_ready  = ($urandom_range(99) < rdy_pct);
    @(negedge i_clk);
    held = (exp_q.size() + SYMS - 1) / SYMS;
    mv   = (held > outst);
    chk("rd_req", o_fifo_rd_req, i_enable & ~i_fifo_empty & (held < BUF_DEPTH));
    chk("busy",   o_busy, held != 0);
    chk("valid",  o_out_valid, mv);
    chk("last",   o_out_last, mv && (hs % FRAME_SYMS == FRAME_SYMS - 1));
    chk("err",    o_err_unexp_val, err_m);
    if (mv) chk("data", o_out_data, exp_q[0]);
    saw_req = o_fifo_rd_req;
    if (i_fifo_rd_data_val) begin
      if (outst == 0) err_m = 1; else outst--;
    end
    ret_val = 0;
    if (o_fifo_rd_req && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      ret_val = 1; ret_data = w; outst++;
      for (int s = 0; s < SYMS; s++) begin
        t = w >> (s * OUT_W);
        exp_q.push_back(t[OUT_W-1:0]);
      end
    end
    if (mv && i_out_ready) begin
      void'(exp_q.pop_front());
      hs++;
    end
  endtask

  task automatic do_reset();
    @(posedge i_clk); #2;
    i_rst_n = 0; en = 0; i_enable = 0; i_out_ready = 0; i_fifo_rd_data_val = 0;
    #1;
    chk("rst_req",   o_fifo_rd_req, 0);
    chk("rst_valid", o_out_valid, 0);
    chk("rst_data",  o_out_data, 0);
    chk("rst_last",  o_out_last, 0);
    chk("rst_busy",  o_busy, 0);
    chk("rst_err",   o_err_unexp_val, 0);
    fifo_q.delete(); exp_q.delete();
    outst = 0; hs = 0; err_m = 0; ret_val = 0; inject = 0;
    @(negedge i_clk); i_rst_n = 1;
  endtask

  initial begin
    int k, hs0;
    #3;
    do_reset();

    // single known word, LSB symbol first
    fifo_q.push_back(32'h44332211); en = 1; rdy_pct = 100;
    repeat (10) step();

    // 8 words back-to-back: 32 symbols in 32 consecutive cycles
    for (int i = 0; i < 8; i++) fifo_q.push_back($urandom);
    hs0 = hs;
    repeat (34) step();
    chk("p2_syms", hs - hs0, 32);
    repeat (4) step();

    // long stall mid-word
    for (int i = 0; i < 4; i++) fifo_q.push_back($urandom);
    repeat (4) step();
    rdy_pct = 0;  repeat (10) step();
    rdy_pct = 100; repeat (20) step();

    // enable dropped right after a read request
    for (int i = 0; i < 3; i++) fifo_q.push_back($urandom);
    k = 0; saw_req = 0;
    while (!saw_req && k < 20) begin step(); k++; end
    chk("p4_req_seen", saw_req, 1);
    en = 0; repeat (12) step();
    chk("p4_drained", exp_q.size(), 0);
    chk("p4_fifo_left", fifo_q.size(), 2);
    en = 1; repeat (25) step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) < 3) fifo_q.push_back($urandom);
      en = ($urandom_range(9) != 0);
      rdy_pct = 60;
      step();
    end
    en = 1; rdy_pct = 100; k = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && k < 300) begin step(); k++; end
    chk("drain", exp_q.size() + fifo_q.size(), 0);

    // unexpected return strobe
    en = 0; repeat (3) step();
    if (outst == 0) inject = 1;
    step();
    repeat (5) step();
    chk("err_sticky", o_err_unexp_val, 1);

    // reset with two words buffered, sym_idx=2
    en = 1; rdy_pct = 100;
    for (int i = 0; i < 4; i++) fifo_q.push_back($urandom);
    repeat (4) step();
    rdy_pct = 0; repeat (2) step();
    do_reset();
    fifo_q.push_back(32'hA1B2C3D4); fifo_q.push_back($urandom);
    en = 1; rdy_pct = 100;
    repeat (15) step();
    chk("post_rst_hs", hs, 8);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
